arith_pipe_unit: RTL and testbench
==================================

# arith_pipe_unit

Parametrised, pipelined successor to the team's four-operand combinational arithmetic block. It accepts four WIDTH-bit operands and a 2-bit opcode through a valid/ready handshake. It computes one of add, subtract, dot-product or bitwise-merge, plus comparison flags, and returns the result two cycles later through a second valid/ready handshake with full back-pressure. It sits between operand sequencers and result consumers in the datapath examples.

## Interface
- WIDTH, 4: operand width in bits; legal range 2 to 16.
- RES_W, 2*WIDTH+1 (derived localparam, not overridable): result width; holds the largest dot-product.
- clk  in  1  sole clock; everything is rising-edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts the beat this cycle.
- a, b, c, d  in  WIDTH each  unsigned operands.
- sel  in  2  opcode: 00 add a+b, 01 sub c-d, 10 dot a*b+c*d, 11 bitwise (a&b)|(c^d).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- result  out  RES_W  zero-extended result.
- flags  out  4  [0] a>b, [1] c==d, [2] result==0, [3] borrow (sub only, c<d).

## Operation
- Transfer rules: an input beat transfers when in_valid && in_ready. An output beat transfers when out_valid && out_ready.
- Stage 1 (S1): registers the operands, sel and a valid bit.
- Stage 2 (S2): registers the computed result and flags, and drives out_valid.
- Stall and enable rules:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en, purely combinational from registered state and out_ready.
  - A bubble in S1 may be filled while S2 is stalled.
- Arithmetic widths:
  - Add is computed in WIDTH+1 bits.
  - Sub is computed in WIDTH+1 bits; it wraps modulo 2^(WIDTH+1) unless saturation is configured.
  - Dot is computed in RES_W bits.
  - Bitwise is computed in WIDTH bits.
  - Every result is zero-extended to RES_W.
- Flags:
  - flags[0] and flags[1] are always computed from the operands, whatever the opcode.
  - flags[2] is computed on the final, post-saturation result.
  - flags[3] = (c<d) when sel==01, otherwise 0.
- While stalled (out_valid && !out_ready), result and flags hold stable.
- No state machine beyond the two valid bits.
- Reset: s1_valid=0, out_valid=0, result=0, flags=0, and in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats.
  - While rst is high, in_ready=0.

## Timing
- Latency: 2 cycles from the accepting edge to out_valid high, when out_ready is held high.
- Throughput: one beat per cycle with out_ready held high.
- Holding out_ready low:
  - The unit absorbs exactly two beats, then drops in_ready.
  - in_ready returns in the same cycle that out_ready rises (combinational path).
- Simultaneous output transfer and new S2 load: the new beat replaces the old one with no idle cycle.
- in_valid may drop without having transferred; nothing is captured.

## Configuration
- ARITH_PIPE_SAT_EN:
  - Defined: sub saturates, so result is 0 when c<d. flags[3]=1 and flags[2]=1.
  - Undefined: sub wraps, e.g. 3-5 gives 2^(WIDTH+1)-2. flags[3]=1 and flags[2]=0.
  - The remaining opcodes are unaffected either way.

## Structure
- Package arith_pipe_pkg holds:
  - the op_e enum (OP_ADD, OP_SUB, OP_DOT, OP_BIT);
  - flag index constants (FLG_GT, FLG_EQ, FLG_ZERO, FLG_BORROW);
  - the function res_w(width) returning 2*width+1.
- One sub-module, arith_pipe_core: purely combinational. It maps operands and sel to result and flags and is instantiated between S1 and S2.
- Handshake and registers stay in the top module.

## Test plan
All scenarios use WIDTH=4.
- Reset: rst high for 3 cycles, then low -> out_valid=0, result=0, flags=0; in_ready=1 on the first cycle after rst falls.
- Add: a=7, b=9, sel=00, out_ready=1 -> two cycles later result=0x010, flags[0]=0.
- Sub: c=3, d=5, sel=01 ->
  - without the macro: result=0x01E, flags[3]=1, flags[2]=0;
  - with ARITH_PIPE_SAT_EN: result=0x000, flags[3]=1, flags[2]=1.
- Dot and bitwise, back-to-back:
  - all operands 15, sel=10 -> result=0x1C2 (450);
  - next beat a=0xC, b=0xA, c=0x6, d=0x3, sel=11 -> result=0x00D;
  - out_valid stays high on consecutive cycles.
- Back-pressure: stream 5 beats with out_ready low for 4 cycles -> in_ready drops after 2 accepted beats, result holds, all 5 results emerge in order with none lost or duplicated.
- Flush: assert rst while 2 beats are in flight -> next cycle out_valid=0; no stale result appears after rst deasserts.

Source files
------------

// File: rtl/arith_pipe_pkg.sv
// rtl/arith_pipe_pkg.sv - shared opcode, flag index and width definitions for arith_pipe_unit
//
// Contents:
//   op_e           2-bit opcode: OP_ADD a+b, OP_SUB c-d, OP_DOT a*b+c*d, OP_BIT (a&b)|(c^d)
//   FLG_*          bit positions inside the 4-bit flags vector
//   res_w(width)   result width needed for the largest dot-product (2*width+1)
package arith_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_DOT = 2'b10,
        OP_BIT = 2'b11
    } op_e;

    localparam int FLG_GT     = 0;
    localparam int FLG_EQ     = 1;
    localparam int FLG_ZERO   = 2;
    localparam int FLG_BORROW = 3;

    function automatic int res_w(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/arith_pipe_core.sv
// rtl/arith_pipe_core.sv - combinational operand-to-result/flags mapping between S1 and S2
//
// Ports:
//   a_i, b_i, c_i, d_i  WIDTH-bit unsigned operands
//   sel_i               opcode (op_e encoding)
//   result_o            RES_W-bit zero-extended result
//   flags_o             [0] a>b, [1] c==d, [2] result==0, [3] borrow on sub
// Configuration:
//   ARITH_PIPE_SAT_EN   when defined, sub clamps to zero instead of wrapping when c<d
module arith_pipe_core
    import arith_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int RES_W = res_w(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [1:0]       sel_i,
    output logic [RES_W-1:0] result_o,
    output logic [3:0]       flags_o
);

    op_e              op;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [RES_W-1:0] dot_w;
    logic [WIDTH-1:0] bit_w;
    logic             borrow;
    logic [RES_W-1:0] res;

    assign op     = op_e'(sel_i);
    assign add_w  = {1'b0, a_i} + {1'b0, b_i};
    // One extra bit so a wrapped difference is taken modulo 2^(WIDTH+1).
    assign sub_w  = {1'b0, c_i} - {1'b0, d_i};
    assign dot_w  = RES_W'(a_i) * RES_W'(b_i) + RES_W'(c_i) * RES_W'(d_i);
    assign bit_w  = (a_i & b_i) | (c_i ^ d_i);
    assign borrow = (c_i < d_i);

    always_comb begin
        res = '0;
        case (op)
            OP_ADD: res = RES_W'(add_w);
`ifdef ARITH_PIPE_SAT_EN
            OP_SUB: res = borrow ? '0 : RES_W'(sub_w);
`else
            OP_SUB: res = RES_W'(sub_w);
`endif
            OP_DOT: res = dot_w;
            OP_BIT: res = RES_W'(bit_w);
            default: res = '0;
        endcase
    end

    assign result_o             = res;
    assign flags_o[FLG_GT]      = (a_i > b_i);
    assign flags_o[FLG_EQ]      = (c_i == d_i);
    // Zero flag looks at the final (possibly saturated) value.
    assign flags_o[FLG_ZERO]    = (res == '0);
    assign flags_o[FLG_BORROW]  = (op == OP_SUB) && borrow;

endmodule

// File: rtl/arith_pipe_unit.sv
// rtl/arith_pipe_unit.sv - two-stage valid/ready arithmetic pipeline around arith_pipe_core
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b, c, d (WIDTH each), sel (2)
//   out_valid/out_ready  result handshake; result (RES_W), flags (4)
// Configuration:
//   ARITH_PIPE_SAT_EN    saturating subtract (handled inside arith_pipe_core)
module arith_pipe_unit
    import arith_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int RES_W = res_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic [3:0]       flags
);

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic [1:0]       sel_q;
    logic [RES_W-1:0] result_q;
    logic [3:0]       flags_q;
    logic [RES_W-1:0] core_result;
    logic [3:0]       core_flags;
    logic             s1_en;
    logic             s2_en;

    // S2 may advance when empty or draining; S1 may advance when empty or
    // when S2 takes its contents, so a bubble in S1 fills during an S2 stall.
    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en && !rst;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (s1_en) s1_valid_d = in_valid;
        if (s2_en) s2_valid_d = s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            sel_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_en && in_valid) begin
                a_q   <= a;
                b_q   <= b;
                c_q   <= c;
                d_q   <= d;
                sel_q <= sel;
            end
        end
    end

    arith_pipe_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .c_i      (c_q),
        .d_i      (d_q),
        .sel_i    (sel_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            // Payload only moves with a real beat so a stalled result stays put.
            if (s2_en && s1_valid_q) begin
                result_q <= core_result;
                flags_q  <= core_flags;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_arith_pipe_unit.sv
// tb/tb_arith_pipe_unit.sv - self-checking bench for arith_pipe_unit (WIDTH=4)
module tb_arith_pipe_unit;

    localparam int W  = 4;
    localparam int RW = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
    logic [1:0]    sel = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] result;
    logic [3:0]    flags;

    int checks   = 0;
    int failures = 0;
    int exp_r_q[$];
    int exp_f_q[$];
    int n_out = 0;

    always #5 clk = ~clk;

    arith_pipe_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [W-1:0]  va, vb, vc, vd;
        logic [1:0]    vsel;
        logic [RW-1:0] res;
        logic [3:0]    flg;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: arithmetic straight from the opcode definitions.
    function automatic void model(input int ma, mb, mc, md, ms, output int r, output int f);
        int m;
        m = 1 << (W + 1);
        case (ms)
            0: r = ma + mb;
`ifdef ARITH_PIPE_SAT_EN
            1: r = (mc < md) ? 0 : mc - md;
`else
            1: r = (mc - md + m) % m;
`endif
            2: r = ma * mb + mc * md;
            default: r = (ma & mb) | (mc ^ md);
        endcase
        f = 0;
        if (ma > mb)              f |= 1;
        if (mc == md)             f |= 2;
        if (r == 0)               f |= 4;
        if (ms == 1 && mc < md)   f |= 8;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs, record accepted beats in the model queue,
    // and check any result that transfers this cycle against the queue head.
    task automatic run_cycle(input bit v, input int ta, tb_, tc, td, ts, input bit ordy, output bit acc);
        int er, ef;
        @(posedge clk);
        #1;
        in_valid  = v;
        a = W'(ta); b = W'(tb_); c = W'(tc); d = W'(td); sel = 2'(ts);
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            model(ta, tb_, tc, td, ts, er, ef);
            exp_r_q.push_back(er);
            exp_f_q.push_back(ef);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_r_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                chk("stream_result", int'(result), exp_r_q.pop_front());
                chk("stream_flags", int'(flags), exp_f_q.pop_front());
            end
        end
    endtask

    initial begin
        bit acc;
        int acc_cnt;
        int held;
        int bp_ops[5][5];
        int bi;

        vecs[0] = '{4'd7,  4'd9, 4'd0, 4'd0,  2'b00, 9'h010, 4'b0010};
`ifdef ARITH_PIPE_SAT_EN
        vecs[1] = '{4'd0,  4'd0, 4'd3, 4'd5,  2'b01, 9'h000, 4'b1100};
        vecs[9] = '{4'd0,  4'd0, 4'd0, 4'd15, 2'b01, 9'h000, 4'b1100};
`else
        vecs[1] = '{4'd0,  4'd0, 4'd3, 4'd5,  2'b01, 9'h01E, 4'b1000};
        vecs[9] = '{4'd0,  4'd0, 4'd0, 4'd15, 2'b01, 9'h011, 4'b1000};
`endif
        vecs[2] = '{4'd15, 4'd15, 4'd15, 4'd15, 2'b10, 9'h1C2, 4'b0010};
        vecs[3] = '{4'hC,  4'hA, 4'h6, 4'h3,  2'b11, 9'h00D, 4'b0001};
        vecs[4] = '{4'd0,  4'd0, 4'd5, 4'd5,  2'b00, 9'h000, 4'b0110};
        vecs[5] = '{4'd0,  4'd0, 4'd9, 4'd9,  2'b01, 9'h000, 4'b0110};
        vecs[6] = '{4'd3,  4'd2, 4'd15, 4'd0, 2'b01, 9'h00F, 4'b0001};
        vecs[7] = '{4'd15, 4'd15, 4'd1, 4'd0, 2'b00, 9'h01E, 4'b0000};
        vecs[8] = '{4'hF,  4'h0, 4'h7, 4'h7,  2'b11, 9'h000, 4'b0111};

        // Reset: 3 cycles high, in_ready low throughout.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("in_ready_during_rst", int'(in_ready), 0);
        end
        rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Table: one beat at a time, result expected two edges later.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = vecs[i].va; b = vecs[i].vb; c = vecs[i].vc; d = vecs[i].vd; sel = vecs[i].vsel;
            step();
            in_valid = 1'b0;
            step();
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d_result", i), int'(result), int'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), int'(flags), int'(vecs[i].flg));
        end
        step();
        chk("idle_out_valid", int'(out_valid), 0);

        // Back-to-back dot then bitwise.
        in_valid = 1'b1;
        a = 4'd15; b = 4'd15; c = 4'd15; d = 4'd15; sel = 2'b10;
        step();
        a = 4'hC; b = 4'hA; c = 4'h6; d = 4'h3; sel = 2'b11;
        step();
        in_valid = 1'b0;
        chk("b2b_valid0", int'(out_valid), 1);
        chk("b2b_dot", int'(result), 'h1C2);
        step();
        chk("b2b_valid1", int'(out_valid), 1);
        chk("b2b_bit", int'(result), 'h00D);
        step();
        chk("b2b_valid2", int'(out_valid), 0);

        // Back-pressure: 5 beats, out_ready low for 4 cycles.
        for (int i = 0; i < 5; i++) begin
            bp_ops[i][0] = i + 1; bp_ops[i][1] = 2 * i; bp_ops[i][2] = 3 + i;
            bp_ops[i][3] = 7 - i; bp_ops[i][4] = i % 4;
        end
        n_out = 0;
        bi = 0;
        acc_cnt = 0;
        held = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            run_cycle(bi < 5, bp_ops[bi % 5][0], bp_ops[bi % 5][1], bp_ops[bi % 5][2],
                      bp_ops[bi % 5][3], bp_ops[bi % 5][4], 1'b0, acc);
            if (acc) begin bi++; acc_cnt++; end
            if (cyc == 2) held = int'(result);
        end
        chk("bp_accepted", acc_cnt, 2);
        chk("bp_in_ready_low", int'(in_ready), 0);
        chk("bp_result_hold", int'(result), held);
        chk("bp_result_head", int'(result), exp_r_q[0]);
        run_cycle(bi < 5, bp_ops[bi % 5][0], bp_ops[bi % 5][1], bp_ops[bi % 5][2],
                  bp_ops[bi % 5][3], bp_ops[bi % 5][4], 1'b1, acc);
        chk("bp_in_ready_return", int'(acc), 1);
        if (acc) bi++;
        for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
            run_cycle(bi < 5, bp_ops[bi % 5][0], bp_ops[bi % 5][1], bp_ops[bi % 5][2],
                      bp_ops[bi % 5][3], bp_ops[bi % 5][4], 1'b1, acc);
            if (acc) bi++;
        end
        chk("bp_outputs", n_out, 5);
        chk("bp_queue_empty", exp_r_q.size(), 0);

        // Flush: two beats in flight, then reset.
        run_cycle(1'b1, 1, 2, 3, 4, 0, 1'b0, acc);
        run_cycle(1'b1, 5, 6, 7, 8, 2, 1'b0, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("flush_in_ready", int'(in_ready), 0);
        step();
        chk("flush_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        exp_r_q.delete();
        exp_f_q.delete();
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, acc);
            chk("flush_no_stale", int'(out_valid), 0);
        end

        // Randomized stream against the reference queue.
        n_out = 0;
        for (int i = 0; i < 400; i++) begin
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                      $urandom_range(0, 3) != 0, acc);
        end
        for (int i = 0; i < 20 && exp_r_q.size() != 0; i++) begin
            run_cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, acc);
        end
        chk("rand_drained", exp_r_q.size(), 0);
        chk("rand_some_outputs", int'(n_out > 100), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
